// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
// Enable vectors are built at MAX_NDIG width and truncated to NDIG by the user.
package seg7_pkg;

    localparam int MAX_NDIG = 16;

    localparam logic [3:0]          BCD_MAX = 4'd9;
    localparam logic [MAX_NDIG-1:0] AN_OFF  = {MAX_NDIG{1'b1}};

    // Active-low one-hot enable for digit slot idx.
    function automatic logic [MAX_NDIG-1:0] an_onehot(input int unsigned idx);
        an_onehot = ~({{(MAX_NDIG-1){1'b0}}, 1'b1} << idx);
    endfunction

endpackage

// File: rtl/seg7_tick.sv
// Free-running prescaler: TICK is high on the last cycle of every PRESCALE-cycle slot.
module seg7_tick
    import seg7_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic CLK,
    input  logic N_RESET,
    output logic TICK
);

    localparam int             CW       = $clog2(PRESCALE);
    localparam logic [CW-1:0]  CNT_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap after the last cycle of the slot.
    always_comb begin
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign TICK = (cnt_q == CNT_LAST);

endmodule

// File: rtl/seg7_scan.sv
// Scan driver for an NDIG-digit common-anode display with a LOAD/READY handshake
// whose captured value is committed only at a frame boundary. NDIG must not exceed 16.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 50000
) (
    input  logic              CLK,
    input  logic              N_RESET,
    input  logic              LOAD,
    input  logic [4*NDIG-1:0] DATA,
    input  logic              BLANK_LZ,
    output logic              READY,
    output logic [3:0]        DIGIT,
    output logic [NDIG-1:0]   AN
);

    localparam int             IW       = $clog2(NDIG);
    localparam logic [IW-1:0]  IDX_LAST = IW'(NDIG - 1);
    localparam logic [NDIG-1:0] AN_BLANK = NDIG'(AN_OFF);

    logic              tick_s;
    logic              frame_end_s;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] stage_q, stage_d;
    logic [4*NDIG-1:0] disp_q, disp_d;
    logic              pending_q, pending_d;
    logic              ready_q;
    logic [3:0]        digit_q, digit_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic [3:0]        nib_s;
    logic              upper_zero_s;

    seg7_tick #(.PRESCALE(PRESCALE)) u_tick (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .TICK    (tick_s)
    );

    assign frame_end_s = tick_s && (idx_q == IDX_LAST);

    // Slot index advances once per prescaler tick.
    always_comb begin
        if (!tick_s) begin
            idx_d = idx_q;
        end else if (idx_q == IDX_LAST) begin
            idx_d = '0;
        end else begin
            idx_d = idx_q + IW'(1);
        end
    end

    // Handshake: a commit at the frame boundary takes priority; LOAD is ignored while pending.
    always_comb begin
        stage_d   = stage_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        if (frame_end_s && pending_q) begin
            disp_d    = stage_q;
            pending_d = 1'b0;
        end else if (LOAD && !pending_q) begin
            stage_d   = DATA;
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Slot evaluation: invalid codes and leading zeros blank the slot and force DIGIT to 0.
    always_comb begin
        nib_s        = disp_q[{idx_q, 2'b00} +: 4];
        upper_zero_s = 1'b1;
        for (int k = 0; k < NDIG; k++) begin
            if ((k >= int'(idx_q)) && (disp_q[4*k +: 4] != 4'd0)) begin
                upper_zero_s = 1'b0;
            end else begin
                upper_zero_s = upper_zero_s;
            end
        end
        if (nib_s > BCD_MAX) begin
            digit_d = 4'd0;
            an_d    = AN_BLANK;
        end else if (BLANK_LZ && (idx_q != '0) && upper_zero_s) begin
            digit_d = 4'd0;
            an_d    = AN_BLANK;
        end else begin
            digit_d = nib_s;
            an_d    = NDIG'(an_onehot(int'(idx_q)));
        end
    end

    // State and output registers; reset blanks the display and drops any pending update.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            idx_q     <= '0;
            stage_q   <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            digit_q   <= 4'd0;
            an_q      <= AN_BLANK;
        end else begin
            idx_q     <= idx_d;
            stage_q   <= stage_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            ready_q   <= !pending_d;
            digit_q   <= digit_d;
            an_q      <= an_d;
        end
    end

    assign READY = ready_q;
    assign DIGIT = digit_q;
    assign AN    = an_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomised and directed bench for seg7_scan (NDIG=4, PRESCALE=4) against a
// cycle-count based reference model.
module tb_seg7_scan;

    localparam int N = 4;
    localparam int P = 4;

    logic        CLK      = 1'b0;
    logic        N_RESET  = 1'b0;
    logic        LOAD     = 1'b0;
    logic        BLANK_LZ = 1'b0;
    logic [15:0] DATA     = 16'h0000;
    logic        READY;
    logic [3:0]  DIGIT;
    logic [3:0]  AN;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_scan #(.NDIG(N), .PRESCALE(P)) dut (
        .CLK      (CLK),
        .N_RESET  (N_RESET),
        .LOAD     (LOAD),
        .DATA     (DATA),
        .BLANK_LZ (BLANK_LZ),
        .READY    (READY),
        .DIGIT    (DIGIT),
        .AN       (AN)
    );

    always #5 CLK = ~CLK;

    // Reference model: slot and frame position derived from cycles since reset release.
    int          m_cyc     = 0;
    logic        m_pend    = 1'b0;
    logic [15:0] m_stage   = 16'h0000;
    logic [15:0] m_disp    = 16'h0000;
    logic        exp_ready = 1'b1;
    logic [3:0]  exp_digit = 4'h0;
    logic [3:0]  exp_an    = 4'hF;

    function automatic logic slot_blank(int cyc, logic [15:0] v, logic blz);
        int          slot = (cyc / P) % N;
        logic [15:0] upper = v >> (4 * slot);
        logic [3:0]  nib = upper[3:0];
        if (nib > 4'd9) return 1'b1;
        if (blz && slot > 0 && upper == 16'h0000) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_an(int cyc, logic [15:0] v, logic blz);
        int slot = (cyc / P) % N;
        if (slot_blank(cyc, v, blz)) return 4'hF;
        return ~(4'b0001 << slot);
    endfunction

    function automatic logic [3:0] model_digit(int cyc, logic [15:0] v, logic blz);
        int          slot = (cyc / P) % N;
        logic [15:0] upper = v >> (4 * slot);
        if (slot_blank(cyc, v, blz)) return 4'h0;
        return upper[3:0];
    endfunction

    always @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            m_cyc     <= 0;
            m_pend    <= 1'b0;
            m_stage   <= 16'h0000;
            m_disp    <= 16'h0000;
            exp_ready <= 1'b1;
            exp_digit <= 4'h0;
            exp_an    <= 4'hF;
        end else begin
            exp_an    <= model_an(m_cyc, m_disp, BLANK_LZ);
            exp_digit <= model_digit(m_cyc, m_disp, BLANK_LZ);
            if (m_pend && (m_cyc % (N * P)) == (N * P - 1)) begin
                m_disp    <= m_stage;
                m_pend    <= 1'b0;
                exp_ready <= 1'b1;
            end else if (LOAD && !m_pend) begin
                m_stage   <= DATA;
                m_pend    <= 1'b1;
                exp_ready <= 1'b0;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] walk;
        repeat (2) cyc();
        n_cmp += 3;
        if (AN !== 4'hF)   begin n_bad++; $display("FAIL reset_an: got %h want f", AN); end
        if (READY !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", READY); end
        if (DIGIT !== 4'h0) begin n_bad++; $display("FAIL reset_digit: got %h want 0", DIGIT); end
        N_RESET = 1'b1;
        for (int i = 0; i < 32; i++) begin
            cyc();
            walk = ~(4'b0001 << ((i / P) % N));
            n_cmp += 2;
            if (AN !== walk) begin n_bad++; $display("FAIL walk_an[%0d]: got %b want %b", i, AN, walk); end
            if (DIGIT !== 4'h0) begin n_bad++; $display("FAIL walk_digit[%0d]: got %h want 0", i, DIGIT); end
        end
    endtask

    // Load a value, wait for its commit, then check one full frame of slots.
    task automatic test_frame(input string nm, input logic [15:0] data, input logic blz,
                              input logic [15:0] want_an, input logic [15:0] want_dig);
        int lat;
        BLANK_LZ = blz;
        DATA     = data;
        LOAD     = 1'b1;
        cyc();
        LOAD = 1'b0;
        n_cmp++;
        if (READY !== 1'b0) begin n_bad++; $display("FAIL %s_ready_drop: got %b want 0", nm, READY); end
        lat = 1;
        while (READY !== 1'b1 && lat <= N * P + 2) begin
            cyc();
            lat++;
            n_cmp++;
            if (READY !== exp_ready) begin n_bad++; $display("FAIL %s_ready_wait: got %b want %b", nm, READY, exp_ready); end
        end
        n_cmp++;
        if (READY !== 1'b1 || lat - 1 > N * P) begin
            n_bad++; $display("FAIL %s_latency: got %0d edges want <= %0d", nm, lat - 1, N * P);
        end
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < P; j++) begin
                cyc();
                n_cmp += 2;
                if (AN !== exp_an) begin n_bad++; $display("FAIL %s_model_an: got %b want %b", nm, AN, exp_an); end
                if (DIGIT !== exp_digit) begin n_bad++; $display("FAIL %s_model_digit: got %h want %h", nm, DIGIT, exp_digit); end
                if (j == 0) begin
                    n_cmp += 2;
                    if (AN !== want_an[4*k +: 4]) begin
                        n_bad++; $display("FAIL %s_slot%0d_an: got %b want %b", nm, k, AN, want_an[4*k +: 4]);
                    end
                    if (DIGIT !== want_dig[4*k +: 4]) begin
                        n_bad++; $display("FAIL %s_slot%0d_digit: got %h want %h", nm, k, DIGIT, want_dig[4*k +: 4]);
                    end
                end
            end
        end
    endtask

    task automatic test_drop();
        logic [15:0] shown;
        BLANK_LZ = 1'b0;
        DATA = 16'h5678; LOAD = 1'b1;
        cyc();
        DATA = 16'h9999;
        cyc();
        LOAD = 1'b0;
        for (int t = 0; t < N * P + 2 && READY !== 1'b1; t++) cyc();
        n_cmp++;
        if (READY !== 1'b1) begin n_bad++; $display("FAIL drop_ready: got %b want 1", READY); end
        for (int f = 0; f < 2; f++) begin
            shown = 16'h0000;
            for (int i = 0; i < N * P; i++) begin
                cyc();
                if (i % P == 0) shown[4*(i/P) +: 4] = DIGIT;
            end
            n_cmp++;
            if (shown !== 16'h5678) begin n_bad++; $display("FAIL drop_frame%0d: got %h want 5678", f, shown); end
        end
    endtask

    task automatic test_random();
        int lz;
        logic [15:0] v;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                v = 16'h0000;
                for (int d = 0; d < N; d++) begin
                    if ($urandom_range(0, 7) == 0) v[4*d +: 4] = 4'($urandom_range(10, 15));
                    else v[4*d +: 4] = 4'($urandom_range(0, 9));
                end
                lz = $urandom_range(0, 4);
                for (int d = N - lz; d < N; d++) v[4*d +: 4] = 4'h0;
                DATA = v;
            end
            LOAD = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 31) == 0) BLANK_LZ = ~BLANK_LZ;
            cyc();
            n_cmp += 4;
            if (AN !== exp_an) begin n_bad++; $display("FAIL rand_an[%0d]: got %b want %b", i, AN, exp_an); end
            if (DIGIT !== exp_digit) begin n_bad++; $display("FAIL rand_digit[%0d]: got %h want %h", i, DIGIT, exp_digit); end
            if (READY !== exp_ready) begin n_bad++; $display("FAIL rand_ready[%0d]: got %b want %b", i, READY, exp_ready); end
            if ($countones(~AN) > 1) begin n_bad++; $display("FAIL rand_onehot[%0d]: got %b want <=1 low", i, AN); end
        end
        LOAD = 1'b0;
    endtask

    task automatic test_reset_mid();
        BLANK_LZ = 1'b0;
        for (int t = 0; t < 2 * N * P && (m_cyc % (N * P)) != 2; t++) cyc();
        for (int t = 0; t < N * P + 2 && READY !== 1'b1; t++) cyc();
        DATA = 16'h0042; LOAD = 1'b1;
        cyc();
        LOAD = 1'b0;
        repeat (3) cyc();
        n_cmp++;
        if (READY !== 1'b0) begin n_bad++; $display("FAIL mid_pending: got %b want 0", READY); end
        #2;
        N_RESET = 1'b0;
        #1;
        n_cmp += 3;
        if (AN !== 4'hF)    begin n_bad++; $display("FAIL mid_async_an: got %b want 1111", AN); end
        if (READY !== 1'b1) begin n_bad++; $display("FAIL mid_async_ready: got %b want 1", READY); end
        if (DIGIT !== 4'h0) begin n_bad++; $display("FAIL mid_async_digit: got %h want 0", DIGIT); end
        cyc();
        N_RESET = 1'b1;
        cyc();
        n_cmp += 2;
        if (AN !== 4'hE)    begin n_bad++; $display("FAIL mid_slot0_an: got %b want 1110", AN); end
        if (DIGIT !== 4'h0) begin n_bad++; $display("FAIL mid_slot0_digit: got %h want 0", DIGIT); end
        for (int i = 0; i < 2 * N * P; i++) begin
            cyc();
            n_cmp += 2;
            if (DIGIT !== 4'h0) begin n_bad++; $display("FAIL mid_discard_digit[%0d]: got %h want 0", i, DIGIT); end
            if (READY !== 1'b1) begin n_bad++; $display("FAIL mid_discard_ready[%0d]: got %b want 1", i, READY); end
        end
    endtask

    initial begin
        test_reset();
        test_frame("load1234", 16'h1234, 1'b0, 16'h7BDE, 16'h1234);
        test_frame("lz0042",   16'h0042, 1'b1, 16'hFFDE, 16'h0042);
        test_frame("lz0000",   16'h0000, 1'b1, 16'hFFFE, 16'h0000);
        test_drop();
        test_frame("inv12A4",  16'h12A4, 1'b0, 16'h7BFE, 16'h1204);
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
